// File: rtl/bu2_arb_pkg.sv
// bu2_arb_pkg: shared definitions for the bu2_arbiter slice.
//   - bu2_state_e : controller FSM states (IDLE/ISSUE/CAPT/RESP)
//   - DEF_WIDTH   : default operand/result width
//   - ID_REQ0/1   : requester identifiers carried on rsp_id
//   - CNT_WIDTH   : width of the optional grant counters (BU2_ARB_CNT_EN)
package bu2_arb_pkg;

   localparam int   DEF_WIDTH = 8;
   localparam logic ID_REQ0   = 1'b0;
   localparam logic ID_REQ1   = 1'b1;
   localparam int   CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CAPT  = 2'd2,
      ST_RESP  = 2'd3
   } bu2_state_e;

endpackage

// File: rtl/bu2_arbiter_if.sv
// bu2_arbiter_if: bundle of every handshake/bus signal around bu2_arbiter.
//   Requesters  : reqN_valid/reqN_data (to arbiter), reqN_ready (from arbiter)
//   Response    : rsp_valid/rsp_data/rsp_id/rsp_ovf (from arbiter), rsp_ready (to arbiter)
//   Shared unit : cu_a/cu_enable (from arbiter), cu_y (from the unit)
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where valid && ready are both high; the sender holds valid and its
// payload stable until that edge, and the receiver may raise ready only
// while it can take the payload on that edge.
// Modports: slave = arbiter side, master = requester/consumer/unit side.
interface bu2_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic             req1_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             rsp_ovf;
   logic [WIDTH-1:0] cu_a;
   logic             cu_enable;
   logic [WIDTH-1:0] cu_y;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready, cu_y,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf,
             cu_a, cu_enable
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, rsp_ready, cu_y,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf,
             cu_a, cu_enable
   );
endinterface

// File: rtl/bu2_module.sv
// bu2_module: the shared registered two's-complement unit.
//   clk, reset : clock and synchronous active-high reset (own reset domain)
//   enable     : when high at a rising edge, y <= ~a + 1
//   a          : operand
//   y          : registered result
module bu2_module #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   always_ff @(posedge clk) begin
      if (reset) begin
         y <= '0;
      end else if (enable) begin
         y <= ~a + 1'b1;
      end
   end
endmodule

// File: rtl/bu2_rr_pick.sv
// bu2_rr_pick: combinational 2-way round-robin picker.
//   valid0/valid1 : requester valids
//   last_id       : requester granted most recently
//   grant         : one-hot grant (bit N = requester N), zero when idle
//   win_id        : winner ID (meaningful only when grant != 0)
module bu2_rr_pick
   import bu2_arb_pkg::*;
(
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_id,
   output logic [1:0] grant,
   output logic       win_id
);
   always_comb begin
      win_id = ID_REQ0;
      grant  = 2'b00;
      // On a tie the requester that was not served last goes first.
      if (valid0 && valid1) begin
         win_id = ~last_id;
      end else if (valid1) begin
         win_id = ID_REQ1;
      end
      if (valid0 || valid1) begin
         grant = (win_id == ID_REQ1) ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: rtl/bu2_arbiter.sv
// bu2_arbiter: shares one bu2_module between two requesters.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : bu2_arbiter_if.slave (requests, response, shared unit)
//   dbg_state    : current FSM state, for observation only
//   grant_cnt0/1 : saturating accept counters, present only when the
//                  macro BU2_ARB_CNT_EN is defined
// Flow: IDLE (accept winner) -> ISSUE (one enabled unit cycle) ->
// CAPT (capture unit output) -> RESP (hold response until taken).
module bu2_arbiter
   import bu2_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   bu2_arbiter_if.slave         bus,
   output bu2_state_e           dbg_state
`ifdef BU2_ARB_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] grant_cnt0,
   output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   bu2_state_e       state_q, state_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic [WIDTH-1:0] cu_a_q, cu_a_d;
   logic             cu_enable_q, cu_enable_d;
`ifdef BU2_ARB_CNT_EN
   logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
`endif

   logic [1:0]       grant;
   logic             win_id;
   logic             accept;
   logic [WIDTH-1:0] win_data;

   bu2_rr_pick u_pick (
      .valid0  (bus.req0_valid),
      .valid1  (bus.req1_valid),
      .last_id (last_q),
      .grant   (grant),
      .win_id  (win_id)
   );

   // Readies are combinational: only the winner, only while idle.
   assign bus.req0_ready = (state_q == ST_IDLE) && grant[0];
   assign bus.req1_ready = (state_q == ST_IDLE) && grant[1];
   assign accept         = (state_q == ST_IDLE) && (grant != 2'b00);
   assign win_data       = (win_id == ID_REQ1) ? bus.req1_data : bus.req0_data;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      id_d        = id_q;
      last_d      = last_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_ovf_d   = rsp_ovf_q;
      cu_a_d      = cu_a_q;
      cu_enable_d = cu_enable_q;
`ifdef BU2_ARB_CNT_EN
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d        = win_data;
               id_d        = win_id;
               // Unit drive is registered, so it is loaded here to be
               // present exactly during the ISSUE cycle.
               cu_a_d      = win_data;
               cu_enable_d = 1'b1;
               state_d     = ST_ISSUE;
`ifdef BU2_ARB_CNT_EN
               if (win_id == ID_REQ0 && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
               if (win_id == ID_REQ1 && cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
`endif
            end
         end
         ST_ISSUE: begin
            cu_a_d      = '0;
            cu_enable_d = 1'b0;
            state_d     = ST_CAPT;
         end
         ST_CAPT: begin
            // The unit updated its output on the ISSUE edge.
            rsp_data_d  = bus.cu_y;
            rsp_ovf_d   = (op_q == MSB_ONLY);
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               last_d      = rsp_id_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         id_q        <= ID_REQ0;
         last_q      <= ID_REQ1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= ID_REQ0;
         rsp_ovf_q   <= 1'b0;
         cu_a_q      <= '0;
         cu_enable_q <= 1'b0;
`ifdef BU2_ARB_CNT_EN
         cnt0_q      <= '0;
         cnt1_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         id_q        <= id_d;
         last_q      <= last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ovf_q   <= rsp_ovf_d;
         cu_a_q      <= cu_a_d;
         cu_enable_q <= cu_enable_d;
`ifdef BU2_ARB_CNT_EN
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
`endif
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign bus.cu_a      = cu_a_q;
   assign bus.cu_enable = cu_enable_q;
   assign dbg_state     = state_q;
`ifdef BU2_ARB_CNT_EN
   assign grant_cnt0    = cnt0_q;
   assign grant_cnt1    = cnt1_q;
`endif

endmodule

// File: tb/tb_bu2_arbiter.sv
// tb_bu2_arbiter: self-checking bench for bu2_arbiter with bu2_module
// attached to the cu_* signals. Define BU2_ARB_CNT_EN to also cover the
// grant counters.
module tb_bu2_arbiter;
   import bu2_arb_pkg::*;

   localparam int W = 8;

   typedef struct {
      bit         id;
      logic [W-1:0] data;
      logic [W-1:0] exp_data;
      bit         exp_ovf;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   bu2_arbiter_if #(.WIDTH(W)) bus ();
   bu2_state_e dbg_state;
`ifdef BU2_ARB_CNT_EN
   logic [7:0] gc0, gc1;
`endif

   bu2_arbiter #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
`ifdef BU2_ARB_CNT_EN
      ,
      .grant_cnt0 (gc0),
      .grant_cnt1 (gc1)
`endif
   );

   bu2_module #(.WIDTH(W)) unit (
      .clk    (clock),
      .reset  (reset),
      .enable (bus.cu_enable),
      .a      (bus.cu_a),
      .y      (bus.cu_y)
   );

   // ---------------- scoreboard ----------------
   int n_vectors = 0;
   int n_miscompares = 0;
   logic [W+1:0] exp_q[$];   // {id, ovf, data}
   bit model_last = 1'b1;    // requester served most recently
   int resp_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clock);
   endtask

   // One full transaction starting from an IDLE negedge; ends at the
   // IDLE negedge right after the response handshake.
   task automatic txn(input bit v0, input logic [W-1:0] d0, input bit v1,
                      input logic [W-1:0] d1, input bit eid,
                      input logic [W-1:0] edata, input bit eovf, input int stall);
      logic [W-1:0] op;
      op = eid ? d1 : d0;
      bus.req0_valid = v0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_data = d1;
      bus.rsp_ready  = 1'b0;
      #1;
      check("ready0_idle", bus.req0_ready, !eid);
      check("ready1_idle", bus.req1_ready, eid);
      step();                                   // T+1: ISSUE
      if (eid) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
      #1;
      check("cu_enable_issue", bus.cu_enable, 1);
      check("cu_a_issue", bus.cu_a, op);
      check("readies_issue", {bus.req1_ready, bus.req0_ready}, 0);
      step();                                   // T+2: CAPT
      check("cu_enable_capt", bus.cu_enable, 0);
      check("cu_a_capt", bus.cu_a, 0);
      check("rsp_valid_capt", bus.rsp_valid, 0);
      step();                                   // T+3: RESP
      resp_cyc = cyc;
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_data", bus.rsp_data, edata);
      check("rsp_id", bus.rsp_id, eid);
      check("rsp_ovf", bus.rsp_ovf, eovf);
      for (int i = 0; i < stall; i++) begin
         step();
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_data", bus.rsp_data, edata);
         check("hold_id", bus.rsp_id, eid);
         check("hold_ovf", bus.rsp_ovf, eovf);
         check("hold_readies", {bus.req1_ready, bus.req0_ready}, 0);
      end
      bus.rsp_ready = 1'b1;
      step();                                   // handshake edge passed
      bus.rsp_ready = 1'b0;
      check("rsp_valid_after", bus.rsp_valid, 0);
      model_last = eid;
   endtask

   // Reference: arbitration rule plus modulo arithmetic negation.
   task automatic txn_model(input bit v0, input logic [W-1:0] d0, input bit v1,
                            input logic [W-1:0] d1, input int stall);
      bit wid;
      int x;
      int r;
      logic [W+1:0] e;
      if (v0 && v1) wid = !model_last;
      else          wid = v1;
      x = wid ? int'(d1) : int'(d0);
      r = ((1 << W) - x) % (1 << W);
      exp_q.push_back({wid, (x == (1 << (W-1))), r[W-1:0]});
      e = exp_q.pop_front();
      txn(v0, d0, v1, d1, e[W+1], e[W-1:0], e[W], stall);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready0"}, bus.req0_ready, 0);
      check({tag, "_ready1"}, bus.req1_ready, 0);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, "_rsp_data"}, bus.rsp_data, 0);
      check({tag, "_rsp_id"}, bus.rsp_id, 0);
      check({tag, "_rsp_ovf"}, bus.rsp_ovf, 0);
      check({tag, "_cu_a"}, bus.cu_a, 0);
      check({tag, "_cu_enable"}, bus.cu_enable, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // ---------------- test ----------------
   vec_t vecs[7];
   int   c0;
   bit   pend0, pend1;
   logic [W-1:0] pd0, pd1;

   initial begin
      vecs[0] = '{id: 1'b0, data: 8'h05, exp_data: 8'hFB, exp_ovf: 1'b0};
      vecs[1] = '{id: 1'b1, data: 8'h80, exp_data: 8'h80, exp_ovf: 1'b1};
      vecs[2] = '{id: 1'b0, data: 8'h00, exp_data: 8'h00, exp_ovf: 1'b0};
      vecs[3] = '{id: 1'b1, data: 8'h01, exp_data: 8'hFF, exp_ovf: 1'b0};
      vecs[4] = '{id: 1'b0, data: 8'h7F, exp_data: 8'h81, exp_ovf: 1'b0};
      vecs[5] = '{id: 1'b1, data: 8'hFF, exp_data: 8'h01, exp_ovf: 1'b0};
      vecs[6] = '{id: 1'b0, data: 8'h81, exp_data: 8'h7F, exp_ovf: 1'b0};

      bus.req0_valid = 1'b0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_data = '0;
      bus.rsp_ready  = 1'b0;
      reset = 1'b1;
      step(); step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Tie alternation straight out of reset: req0 first, 4-cycle spacing.
      txn(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFF, 1'b0, 0);
      c0 = resp_cyc;
      txn(1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 8'hFE, 1'b0, 0);
      check("alt_gap1", resp_cyc - c0, 4);
      c0 = resp_cyc;
      txn(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFF, 1'b0, 0);
      check("alt_gap2", resp_cyc - c0, 4);

      // Table of lone requests.
      foreach (vecs[i]) begin
         txn(!vecs[i].id, vecs[i].data, vecs[i].id, vecs[i].data,
             vecs[i].id, vecs[i].exp_data, vecs[i].exp_ovf, 0);
      end

      // Backpressure with the loser waiting, then immediate next accept.
      txn_model(1'b1, 8'h33, 1'b1, 8'h44, 10);
      txn_model(1'b1, 8'h33, 1'b1, 8'h44, 0);

      // Reset during ISSUE drops the transaction.
      bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
      step();
      check("pre_reset_issue", bus.cu_enable, 1);
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      step();
      check_all_zero("midreset");
      reset = 1'b0;
      model_last = 1'b1;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("no_rsp_after_reset", bus.rsp_valid, 0);
      end
      bus.rsp_ready = 1'b0;
      txn(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'hEF, 1'b0, 0);

      // Randomized traffic against the reference model.
      pend0 = 1'b0; pend1 = 1'b0; pd0 = '0; pd1 = '0;
      for (int r = 0; r < 60; r++) begin
         if (!pend0) begin pend0 = 1'($urandom_range(0, 1)); pd0 = W'($urandom); end
         if (!pend1) begin pend1 = 1'($urandom_range(0, 1)); pd1 = W'($urandom); end
         if (!pend0 && !pend1) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            #1;
            check("idle_readies", {bus.req1_ready, bus.req0_ready}, 0);
            step();
         end else begin
            txn_model(pend0, pd0, pend1, pd1, int'($urandom_range(0, 3)));
            if (pend0 && pend1) begin
               if (model_last) pend1 = 1'b0; else pend0 = 1'b0;
            end else begin
               pend0 = 1'b0; pend1 = 1'b0;
            end
         end
      end

`ifdef BU2_ARB_CNT_EN
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      reset = 1'b1;
      step(); step();
      check("cnt0_reset", gc0, 0);
      check("cnt1_reset", gc1, 0);
      reset = 1'b0;
      model_last = 1'b1;
      step();
      for (int i = 0; i < 300; i++) begin
         txn(1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'hF0, 1'b0, 0);
      end
      check("cnt1_sat", gc1, 255);
      check("cnt0_zero", gc0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/bu2_arbiter.md
# bu2_arbiter

Sequencing controller that shares one registered two's-complement unit (`bu2_module`: `Y <= ~A + 1` on the clock edge where `enable` is high) between two requesters. Each requester hands over an operand through a valid/ready handshake. The controller arbitrates round-robin, drives the unit for exactly one enabled cycle and captures its result. It returns the result with the requester ID on a single valid/ready response channel. It sits between the requester logic and the shared unit, and it is the only driver of the unit's `A` and `enable` inputs.

## Interface
- `WIDTH`, default 8: operand and result width. Must match the unit's width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `req0_valid` in 1: requester 0 holds an operand.
- `req0_data` in WIDTH: requester 0 operand.
- `req0_ready` out 1: requester 0 operand accepted at this edge.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out WIDTH: two's complement of the accepted operand.
- `rsp_id` out 1: ID of the requester that was served.
- `rsp_ovf` out 1: the operand was the most-negative value (MSB only set), so the result equals the operand.
- `cu_a` out WIDTH: operand to the shared unit.
- `cu_enable` out 1: enable to the shared unit.
- `cu_y` in WIDTH: registered output of the shared unit.

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - `req*_ready` is asserted combinationally, and only to the arbitration winner, while that winner's valid is high.
  - On the handshake edge, latch operand and ID, then go to ISSUE.
  - With no request valid, stay in IDLE.
- Arbitration:
  - A lone valid requester wins.
  - When both are valid, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- ISSUE: `cu_enable`=1, `cu_a`=latched operand, for one cycle only. Then go to CAPT.
- CAPT: register `cu_y` into `rsp_data`. Set `rsp_ovf` from the latched operand. Go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_data`, `rsp_id` and `rsp_ovf` stay stable until `rsp_valid && rsp_ready`.
  - On that edge, go to IDLE and update the last-grant pointer.
- Outside ISSUE, `cu_enable`=0 and `cu_a`=0.
- A requester must hold its valid and data stable until it sees ready. The controller never drops an un-accepted request.
- Arithmetic is modulo 2^WIDTH:
  - Operand 0 gives result 0 with `rsp_ovf`=0.
  - Operand 0x80 gives result 0x80 with `rsp_ovf`=1.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_ovf`=0, `cu_a`=0, `cu_enable`=0. State is IDLE and the last-grant pointer is 1.
- Readies are still combinational during reset, but the controller ignores any handshake while `reset` is high.
- Latency, with the accept edge at end of cycle T:
  - T+1: ISSUE.
  - T+2: CAPT.
  - T+3: RESP, with `rsp_valid` high.
- With `rsp_ready` held high, throughput is one transaction per 4 cycles. The next accept can happen in the IDLE cycle directly after the response edge.
- Backpressure: while `rsp_ready`=0, RESP holds indefinitely and both readies stay 0.
- Reset mid-operation: at the reset edge, the in-flight transaction is discarded with no response, and all outputs return to their reset values. The shared unit's own reset is driven separately.
- Simultaneous events: a new request arriving during RESP is not accepted until IDLE.

## Configuration
- Macro: `BU2_ARB_CNT_EN`.
- Defined: adds outputs `grant_cnt0` and `grant_cnt1`, each 8 bits.
  - Each increments on its requester's accept edge and saturates at 255.
  - Both reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `bu2_arb_pkg` holds:
  - the FSM state typedef (IDLE/ISSUE/CAPT/RESP);
  - default `WIDTH`=8;
  - requester ID constants 0 and 1;
  - counter width 8.
- Sub-module `bu2_rr_pick`: combinational 2-way round-robin picker.
  - Inputs: two valids and the last-grant pointer.
  - Outputs: grant one-hot and winner ID.
- The bench instantiates `bu2_module` on the `cu_*` ports.

## Test plan
- Reset, then a lone `req0` with 0x05 and `rsp_ready`=1 → accept edge T. At T+1, `cu_enable`=1 and `cu_a`=0x05. At T+3, `rsp_valid`=1, `rsp_data`=0xFB, `rsp_id`=0, `rsp_ovf`=0.
- Both requesters held valid, `req0`=0x01 and `req1`=0x02 → responses alternate: id0/0xFF, then id1/0xFE, then id0, with 4 cycles between responses.
- Operand 0x80 → `rsp_data`=0x80, `rsp_ovf`=1. Operand 0x00 → `rsp_data`=0x00, `rsp_ovf`=0.
- `rsp_ready`=0 for 10 cycles in RESP → outputs stay stable and both readies stay 0. Releasing `rsp_ready` completes the transaction, and the next request is accepted in the IDLE cycle that follows.
- `reset` pulsed during ISSUE → no response is emitted, all outputs read 0, and the next tie goes to requester 0.
- With `BU2_ARB_CNT_EN` defined, 300 grants to `req1` → `grant_cnt1`=255 and `grant_cnt0`=0.
